// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use detection.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [3:0]      in_alu_op,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] store_data,
  output logic            valid_q,
  output logic [XLEN-1:0] pc_q,
  output logic [RA_W-1:0] rd_addr_q,
  output logic            reg_write_q,
  output logic            mem_read_q,
  output logic            load_use_stall
);

  // Registered instruction payload; an all-zero value is a bubble (alu_op = ADD).
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [3:0]      alu_op;
    logic [RA_W-1:0] rd_addr;
    logic            reg_write;
    logic            mem_read;
  } idex_t;

  idex_t           st_q;
  idex_t           st_d;
  logic            load_use_c;
  logic [XLEN-1:0] rs1_fwd_c;
  logic [XLEN-1:0] rs2_fwd_c;

  // Load-use: registered load writes a register the decode instruction reads.
  always_comb begin
    load_use_c = 1'b0;
    if (in_valid && st_q.valid && st_q.mem_read && (st_q.rd_addr != '0) &&
        ((st_q.rd_addr == in_rs1_addr) || (st_q.rd_addr == in_rs2_addr))) begin
      load_use_c = 1'b1;
    end
  end

  // Next state: bubble on flush/load-use, hold on stall, else capture decode.
  always_comb begin
    st_d = st_q;
    if (flush || load_use_c) begin
      st_d = '0;
    end else if (!stall) begin
      if (in_valid) begin
        st_d.valid     = 1'b1;
        st_d.pc        = in_pc;
        st_d.rs1_addr  = in_rs1_addr;
        st_d.rs2_addr  = in_rs2_addr;
        st_d.rs1_data  = in_rs1_data;
        st_d.rs2_data  = in_rs2_data;
        st_d.imm       = in_imm;
        st_d.use_imm   = in_use_imm;
        st_d.alu_op    = in_alu_op;
        st_d.rd_addr   = in_rd_addr;
        st_d.reg_write = in_reg_write;
        st_d.mem_read  = in_mem_read;
      end else begin
        st_d = '0;
      end
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  // Forwarding: EX/MEM has priority over MEM/WB; x0 is never forwarded.
  always_comb begin
    rs1_fwd_c = st_q.rs1_data;
    if (exmem_reg_write && (exmem_rd_addr == st_q.rs1_addr) && (st_q.rs1_addr != '0)) begin
      rs1_fwd_c = exmem_result;
    end else if (memwb_reg_write && (memwb_rd_addr == st_q.rs1_addr) && (st_q.rs1_addr != '0)) begin
      rs1_fwd_c = memwb_result;
    end

    rs2_fwd_c = st_q.rs2_data;
    if (exmem_reg_write && (exmem_rd_addr == st_q.rs2_addr) && (st_q.rs2_addr != '0)) begin
      rs2_fwd_c = exmem_result;
    end else if (memwb_reg_write && (memwb_rd_addr == st_q.rs2_addr) && (st_q.rs2_addr != '0)) begin
      rs2_fwd_c = memwb_result;
    end
  end

  // Operand select and pass-through outputs.
  assign a              = rs1_fwd_c;
  assign b              = st_q.use_imm ? st_q.imm : rs2_fwd_c;
  assign store_data     = rs2_fwd_c;
  assign alu_op         = st_q.alu_op;
  assign valid_q        = st_q.valid;
  assign pc_q           = st_q.pc;
  assign rd_addr_q      = st_q.rd_addr;
  assign reg_write_q    = st_q.reg_write;
  assign mem_read_q     = st_q.mem_read;
  assign load_use_stall = load_use_c;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table with scoreboard plus hand sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_use_imm, in_reg_write, in_mem_read;
  logic [3:0]  in_alu_op;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] a, b, store_data, pc_q;
  logic [3:0]  alu_op;
  logic        valid_q, reg_write_q, mem_read_q, load_use_stall;
  logic [4:0]  rd_addr_q;

  int n_total = 0;
  int n_pass  = 0;

  id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_alu_op(in_alu_op), .in_rd_addr(in_rd_addr),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .a(a), .b(b), .alu_op(alu_op), .store_data(store_data), .valid_q(valid_q), .pc_q(pc_q),
    .rd_addr_q(rd_addr_q), .reg_write_q(reg_write_q), .mem_read_q(mem_read_q),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs1a;
    logic [31:0] rs1d;
    logic [4:0]  rs2a;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  op;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        vld;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_sd;
    logic [3:0]  exp_op;
    logic        exp_valid;
  } vec_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  op;
    logic        valid;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; in_valid = 0; in_pc = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_use_imm = 0; in_alu_op = 0; in_rd_addr = 0; in_reg_write = 0; in_mem_read = 0;
    exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                             input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [3:0] op,
                             input logic [4:0] rd, input logic mr);
    in_valid = 1; in_pc = pc; in_rs1_addr = rs1a; in_rs1_data = rs1d;
    in_rs2_addr = rs2a; in_rs2_data = rs2d; in_alu_op = op; in_rd_addr = rd;
    in_reg_write = 1; in_mem_read = mr; in_use_imm = 0; in_imm = 0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    clear_inputs();
    rst_n = 0;

    //        rs1a  rs1d          rs2a  rs2d   imm           ui  op     exwe exrd  exres         wbwe wbrd  wbres  vld  a             b             sd            op     v
    vecs[0] = '{5'd1, 32'd10,     5'd2, 32'd5, 32'd0,        1'b0, 4'd1, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 32'd10,       32'd5,        32'd5,        4'd1, 1'b1};
    vecs[1] = '{5'd1, 32'd5,      5'd2, 32'd99, 32'd2,       1'b1, 4'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0, 1'b1, 32'd5,        32'd2,        32'd99,       4'd3, 1'b1};
    vecs[2] = '{5'd3, 32'd100,    5'd0, 32'd0, 32'd0,        1'b0, 4'd0, 1'b1, 5'd3, 32'd15,       1'b1, 5'd3, 32'd7, 1'b1, 32'd15,       32'd0,        32'd0,        4'd0, 1'b1};
    vecs[3] = '{5'd3, 32'd100,    5'd0, 32'd0, 32'd0,        1'b0, 4'd0, 1'b0, 5'd3, 32'd15,       1'b1, 5'd3, 32'd7, 1'b1, 32'd7,        32'd0,        32'd0,        4'd0, 1'b1};
    vecs[4] = '{5'd0, 32'd0,      5'd0, 32'd0, 32'd0,        1'b0, 4'd0, 1'b1, 5'd0, 32'd15,       1'b1, 5'd0, 32'd7, 1'b1, 32'd0,        32'd0,        32'd0,        4'd0, 1'b1};
    vecs[5] = '{5'd5, 32'd1,      5'd7, 32'd2, 32'd0,        1'b0, 4'd0, 1'b1, 5'd8, 32'd44,       1'b1, 5'd7, 32'd33, 1'b1, 32'd1,       32'd33,       32'd33,       4'd0, 1'b1};
    vecs[6] = '{5'd5, 32'd1,      5'd7, 32'd2, 32'hFFFFFFF0, 1'b1, 4'd0, 1'b1, 5'd7, 32'd55,       1'b0, 5'd0, 32'd0, 1'b1, 32'd1,        32'hFFFFFFF0, 32'd55,       4'd0, 1'b1};
    vecs[7] = '{5'd3, 32'd123,    5'd4, 32'd456, 32'd9,      1'b0, 4'd1, 1'b1, 5'd3, 32'd15,       1'b0, 5'd0, 32'd0, 1'b0, 32'd0,        32'd0,        32'd0,        4'd0, 1'b0};
    vecs[8] = '{5'd9, 32'd1,      5'd9, 32'd2, 32'd0,        1'b0, 4'd2, 1'b1, 5'd9, 32'h80000000, 1'b1, 5'd9, 32'd3, 1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 4'd2, 1'b1};

    // Reset state
    step(); step();
    check("rst_valid", 32'(valid_q), 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_b", b, 32'd0);
    check("rst_sd", store_data, 32'd0);
    check("rst_lus", 32'(load_use_stall), 32'd0);
    rst_n = 1;
    step();

    // Table vectors through the scoreboard
    for (int i = 0; i < 9; i++) begin
      in_valid = vecs[i].vld; in_pc = 32'h1000 + 32'(i * 4);
      in_rs1_addr = vecs[i].rs1a; in_rs1_data = vecs[i].rs1d;
      in_rs2_addr = vecs[i].rs2a; in_rs2_data = vecs[i].rs2d;
      in_imm = vecs[i].imm; in_use_imm = vecs[i].use_imm; in_alu_op = vecs[i].op;
      in_rd_addr = 5'(i + 1); in_reg_write = 1; in_mem_read = 0;
      exmem_reg_write = vecs[i].ex_we; exmem_rd_addr = vecs[i].ex_rd; exmem_result = vecs[i].ex_res;
      memwb_reg_write = vecs[i].wb_we; memwb_rd_addr = vecs[i].wb_rd; memwb_result = vecs[i].wb_res;
      e.a = vecs[i].exp_a; e.b = vecs[i].exp_b; e.sd = vecs[i].exp_sd;
      e.op = vecs[i].exp_op; e.valid = vecs[i].exp_valid;
      e.pc = vecs[i].vld ? 32'h1000 + 32'(i * 4) : 32'd0;
      sb.push_back(e);
      step();
      if (sb.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_a", i), a, e.a);
        check($sformatf("v%0d_b", i), b, e.b);
        check($sformatf("v%0d_sd", i), store_data, e.sd);
        check($sformatf("v%0d_op", i), 32'(alu_op), 32'(e.op));
        check($sformatf("v%0d_valid", i), 32'(valid_q), 32'(e.valid));
        check($sformatf("v%0d_pc", i), pc_q, e.pc);
      end
    end
    clear_inputs();
    step();

    // Load-use: lw x4 followed by a consumer of x4
    drive_instr(32'h200, 5'd1, 32'd0, 5'd2, 32'd0, 4'd0, 5'd4, 1'b1);
    step();
    drive_instr(32'h204, 5'd1, 32'd0, 5'd4, 32'd0, 4'd0, 5'd6, 1'b0);
    #1;
    check("lu_stall", 32'(load_use_stall), 32'd1);
    stall = 1;
    step();
    check("lu_bubble_valid", 32'(valid_q), 32'd0);
    check("lu_bubble_rw", 32'(reg_write_q), 32'd0);
    check("lu_bubble_mr", 32'(mem_read_q), 32'd0);
    check("lu_release", 32'(load_use_stall), 32'd0);
    stall = 0;
    step();
    check("lu_consumer_valid", 32'(valid_q), 32'd1);
    check("lu_consumer_rd", 32'(rd_addr_q), 32'd6);
    // Load into x0 never stalls
    drive_instr(32'h208, 5'd1, 32'd0, 5'd2, 32'd0, 4'd0, 5'd0, 1'b1);
    step();
    drive_instr(32'h20C, 5'd0, 32'd0, 5'd0, 32'd0, 4'd0, 5'd6, 1'b0);
    #1;
    check("lu_x0", 32'(load_use_stall), 32'd0);
    step();

    // Stall holds registers while inputs change; forwarding still re-evaluates
    drive_instr(32'h100, 5'd10, 32'd11, 5'd12, 32'd22, 4'd1, 5'd5, 1'b0);
    step();
    check("st_load_a", a, 32'd11);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'($urandom); in_pc = $urandom; in_rs1_addr = 5'($urandom);
      in_rs2_addr = 5'($urandom); in_rs1_data = $urandom; in_rs2_data = $urandom;
      in_imm = $urandom; in_use_imm = 1'($urandom); in_alu_op = 4'($urandom_range(0, 3));
      in_rd_addr = 5'($urandom); in_mem_read = 0;
      step();
      check($sformatf("st%0d_a", k), a, 32'd11);
      check($sformatf("st%0d_b", k), b, 32'd22);
      check($sformatf("st%0d_pc", k), pc_q, 32'h100);
      check($sformatf("st%0d_op", k), 32'(alu_op), 32'd1);
      check($sformatf("st%0d_valid", k), 32'(valid_q), 32'd1);
    end
    memwb_reg_write = 1; memwb_rd_addr = 5'd10; memwb_result = 32'd77;
    #1;
    check("st_fwd_a", a, 32'd77);
    flush = 1;
    step();
    check("fl_valid", 32'(valid_q), 32'd0);
    check("fl_op", 32'(alu_op), 32'd0);
    clear_inputs();
    step();

    // Asynchronous reset between edges
    drive_instr(32'h300, 5'd1, 32'd42, 5'd2, 32'd43, 4'd1, 5'd7, 1'b0);
    step();
    check("ar_pre_valid", 32'(valid_q), 32'd1);
    clear_inputs();
    #2;
    rst_n = 0;
    #1;
    check("ar_valid", 32'(valid_q), 32'd0);
    check("ar_a", a, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU in the pipelined RV32 core. Each cycle it captures one decoded instruction and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU's `a`, `b` and `alu_op` inputs. It also detects load-use hazards and requests a one-cycle stall from the front end.

## Interface
- `XLEN`, 32, datapath width
- `RA_W`, 5, register-address width
- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, asynchronous, active-low
- `stall` in 1: hold current contents (from hazard/memory control)
- `flush` in 1: replace captured instruction with a bubble (branch mispredict)
- `in_valid` in 1: decode-stage instruction valid
- `in_pc` in XLEN: instruction PC
- `in_rs1_addr`, `in_rs2_addr` in RA_W: source register addresses
- `in_rs1_data`, `in_rs2_data` in XLEN: register-file read data
- `in_imm` in XLEN: sign-extended immediate
- `in_use_imm` in 1: `b` takes immediate instead of rs2
- `in_alu_op` in 4: ALU opcode (ADD=0000, SUB=0001, SLT=0010, SLLI=0011)
- `in_rd_addr` in RA_W: destination register
- `in_reg_write` in 1: instruction writes rd
- `in_mem_read` in 1: instruction is a load
- `exmem_reg_write` in 1, `exmem_rd_addr` in RA_W, `exmem_result` in XLEN: EX/MEM forwarding source
- `memwb_reg_write` in 1, `memwb_rd_addr` in RA_W, `memwb_result` in XLEN: MEM/WB forwarding source
- `a` out XLEN: ALU operand A
- `b` out XLEN: ALU operand B
- `alu_op` out 4: registered opcode
- `store_data` out XLEN: forwarded rs2 value, regardless of `in_use_imm`
- `valid_q`, `pc_q`, `rd_addr_q`, `reg_write_q`, `mem_read_q` out: registered pass-through to EX/MEM
- `load_use_stall` out 1: front end must hold decode and assert `stall`

## Operation
- Registered state: valid, pc, rs1/rs2 addr, rs1/rs2 data, imm, use_imm, alu_op, rd_addr, reg_write, mem_read.
- Update priority per rising edge:
  - `flush` loads a bubble: valid=0, reg_write=0, mem_read=0, alu_op=ADD. Other fields are don't-care but are set to 0.
  - else `stall` holds all registers.
  - else captures `in_*`.
  - If `in_valid`=0, capture as a bubble.
- `load_use_stall` also loads a bubble. It is equivalent to `flush` on the ID/EX register; decode holds externally.
- Forwarding is combinational from the registered addresses; apply separately for rs1 and rs2:
  - If `exmem_reg_write` and `exmem_rd_addr`==rs_q and rs_q≠0, use `exmem_result`.
  - else if `memwb_reg_write` and `memwb_rd_addr`==rs_q and rs_q≠0, use `memwb_result`.
  - else use the registered data.
- Register x0 is never forwarded; its operand is the registered data, which the register file guarantees is 0.
- `a` = forwarded rs1. `b` = use_imm_q ? imm_q : forwarded rs2. `store_data` = forwarded rs2.
- `load_use_stall` = `in_valid` & valid_q & mem_read_q & rd_addr_q≠0 & (rd_addr_q==`in_rs1_addr` | rd_addr_q==`in_rs2_addr`). Combinational.
- When `valid_q`=0, forwarding still computes, but downstream ignores it.

## Timing
- Reset (asynchronous on `rst_n` low): all registered state is 0 and alu_op=ADD.
  - Resulting outputs: valid_q=0, a=0, b=0, store_data=0, load_use_stall=0.
  - Outputs may differ only if forwarding inputs are active during reset.
- Latency: one cycle from `in_*` to the registered outputs.
- Forwarded `a`/`b`/`store_data` respond in the same cycle as the forwarding inputs.
- During `stall`, raw operands are held, but `a`/`b` re-evaluate each cycle as the forwarding sources change.
- Simultaneous `flush`+`stall`: `flush` wins.
- Reset asserted mid-stall clears state immediately. No pending hazard survives reset.

## Test plan
- Reset then capture: release `rst_n`, drive rs1_data=10, rs2_data=5, alu_op=SUB, use_imm=0, no forwarding hits → next cycle a=10, b=5, alu_op=0001, valid_q=1.
- Immediate select: rs1_data=5, imm=2, use_imm=1, alu_op=SLLI, rs2_data=99 → b=2, store_data=99, a=5.
- Forwarding priority: rs1_q=3; exmem (rd=3, result=15, we=1); memwb (rd=3, result=7, we=1) → a=15. Drop exmem_we → a=7. Set rs1_q=0 with the same hits → a=registered data (0).
- Load-use: registered lw with rd=4, mem_read_q=1; decode presents rs2=4 with in_valid=1 → load_use_stall=1 in that cycle; next cycle valid_q=0, reg_write_q=0. The same instruction with rd=0 → load_use_stall=0.
- Stall/flush: load an instruction, assert `stall` for 3 cycles with changing `in_*` → registers unchanged. Assert `flush` and `stall` together → valid_q=0, alu_op=0000.
- Async reset mid-operation: pulse `rst_n` low between clock edges while valid_q=1 → valid_q=0 immediately, without waiting for a clock edge.
